// File: rtl/five_bit_rom_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : five_bit_rom_decoder
//  Purpose  : Decodes a 5-bit code into a 5-bit one-hot word through a small
//             ROM table. Each accepted code is queued, together with an error
//             bit, in a 2-entry FIFO. Sticky error flag, plus an optional
//             saturating count of invalid codes.
//  Ports    : clk         - system clock, rising edge
//             rst_n       - asynchronous active-low reset
//             in_code     - [4:0] code to decode
//             in_valid    - in_code is valid this cycle
//             in_ready    - FIFO can accept a code (occupancy < 2)
//             out_onehot  - [4:0] decoded word at the queue head
//             out_err     - the queue-head entry came from an invalid code
//             out_valid   - queue head holds an entry
//             out_ready   - consumer takes the head entry this cycle
//             clr_err     - single-cycle clear of err_flag / err_cnt
//             err_flag    - sticky: an invalid code was accepted
//             err_cnt     - [7:0] count of invalid codes
//  Config   : FIVE_BIT_DECODER_ERRCNT_EN - when defined, err_cnt is a
//             saturating 8-bit counter. Otherwise err_cnt is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module five_bit_rom_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] out_onehot,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       clr_err,
  output logic       err_flag,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_e;

  occ_e       state_q, state_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [5:0] mem_q [2];              // {onehot, err}
  logic       err_flag_q, err_flag_d;

  logic [4:0] dec_onehot;
  logic       dec_err;
  logic       push;
  logic       pop;

  // ROM decode table; any unlisted code is invalid and decodes to zero.
  always_comb begin
    dec_onehot = 5'b00000;
    dec_err    = 1'b0;
    case (in_code)
      5'd1:    dec_onehot = 5'b00001;
      5'd0:    dec_onehot = 5'b00010;
      5'd2:    dec_onehot = 5'b00100;
      5'd3:    dec_onehot = 5'b01000;
      5'd17:   dec_onehot = 5'b10000;
      default: dec_err    = 1'b1;
    endcase
  end

  // Handshakes depend only on registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy next-state and pointer updates.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case (state_q)
      S_EMPTY: if (push) state_d = S_ONE;
      S_ONE: begin
        if (push && !pop)      state_d = S_FULL;
        else if (!push && pop) state_d = S_EMPTY;
      end
      S_FULL:  if (pop) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= 6'd0;
      mem_q[1] <= 6'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= {dec_onehot, dec_err};
    end
  end

  // Head is gated so an empty queue never shows a stale entry.
  assign out_onehot = out_valid ? mem_q[rd_ptr_q][5:1] : 5'b00000;
  assign out_err    = out_valid ? mem_q[rd_ptr_q][0]   : 1'b0;

  // Sticky error flag: setting takes priority over a coincident clear.
  always_comb begin
    err_flag_d = err_flag_q;
    if (push && dec_err) err_flag_d = 1'b1;
    else if (clr_err)    err_flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_flag_q <= 1'b0;
    else        err_flag_q <= err_flag_d;
  end

  assign err_flag = err_flag_q;

`ifdef FIVE_BIT_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       cnt_inc;

  assign cnt_inc = push && dec_err;

  // A clear coinciding with an increment leaves a count of one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err)                       err_cnt_d = cnt_inc ? 8'd1 : 8'd0;
    else if (cnt_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_five_bit_rom_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_five_bit_rom_decoder
//  Purpose  : Directed self-checking bench for five_bit_rom_decoder.
//             Expected err_cnt values follow FIVE_BIT_DECODER_ERRCNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_five_bit_rom_decoder;

  logic       clk;
  logic       rst_n;
  logic [4:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] out_onehot;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic       clr_err;
  logic       err_flag;
  logic [7:0] err_cnt;

  int n_checks;
  int n_errors;

  five_bit_rom_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_err    (clr_err),
    .err_flag   (err_flag),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef FIVE_BIT_DECODER_ERRCNT_EN
    return (n > 255) ? 32'd255 : 32'(n);
`else
    return (n > 0) ? 32'd0 : 32'd0 + 32'(n) * 0;
`endif
  endfunction

  logic [4:0] codes  [5];
  logic [4:0] onehot [5];

  initial begin
    n_checks = 0;
    n_errors = 0;
    codes[0] = 5'd1;  onehot[0] = 5'b00001;
    codes[1] = 5'd0;  onehot[1] = 5'b00010;
    codes[2] = 5'd2;  onehot[2] = 5'b00100;
    codes[3] = 5'd3;  onehot[3] = 5'b01000;
    codes[4] = 5'd17; onehot[4] = 5'b10000;

    rst_n     = 1'b0;
    in_code   = 5'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    #12;
    // Reset values while rst_n is low.
    check("rst_in_ready",  32'(in_ready),   32'd1);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_onehot",    32'(out_onehot), 32'd0);
    check("rst_out_err",   32'(out_err),    32'd0);
    check("rst_err_flag",  32'(err_flag),   32'd0);
    check("rst_err_cnt",   32'(err_cnt),    32'd0);
    rst_n = 1'b1;
    step();

    // Valid codes streamed with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_code  = codes[i];
      in_valid = 1'b1;
      step();
      check($sformatf("seq_valid_%0d", i),  32'(out_valid),  32'd1);
      check($sformatf("seq_onehot_%0d", i), 32'(out_onehot), 32'(onehot[i]));
      check($sformatf("seq_err_%0d", i),    32'(out_err),    32'd0);
    end
    in_valid = 1'b0;
    step();
    check("seq_drain_valid", 32'(out_valid), 32'd0);
    check("seq_err_flag",    32'(err_flag),  32'd0);

    // Back-pressure: two invalid codes fill the FIFO.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 5'd4;
    step();
    in_code = 5'd5;
    step();
    check("bp_in_ready",  32'(in_ready),   32'd0);
    check("bp_onehot",    32'(out_onehot), 32'd0);
    check("bp_out_err",   32'(out_err),    32'd1);
    check("bp_err_flag",  32'(err_flag),   32'd1);
    check("bp_err_cnt",   32'(err_cnt),    cnt_exp(2));
    in_code = 5'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold_ready_%0d", i), 32'(in_ready),  32'd0);
      check($sformatf("bp_hold_err_%0d", i),   32'(out_err),   32'd1);
    end
    out_ready = 1'b1;
    step();  // pop code 4, push blocked
    check("bp_pop1_onehot", 32'(out_onehot), 32'd0);
    check("bp_pop1_err",    32'(out_err),    32'd1);
    check("bp_pop1_ready",  32'(in_ready),   32'd1);
    step();  // pop code 5, push code 1
    check("bp_pop2_onehot", 32'(out_onehot), 32'h01);
    check("bp_pop2_err",    32'(out_err),    32'd0);
    check("bp_pop2_valid",  32'(out_valid),  32'd1);
    in_valid = 1'b0;
    step();
    check("bp_drain_valid", 32'(out_valid), 32'd0);
    check("bp_err_cnt_end", 32'(err_cnt),   cnt_exp(2));

    // Simultaneous push and pop with one entry queued.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 5'd2;
    step();
    check("pp_head_before", 32'(out_onehot), 32'h04);
    in_code   = 5'd3;
    out_ready = 1'b1;
    step();
    check("pp_valid",    32'(out_valid),  32'd1);
    check("pp_in_ready", 32'(in_ready),   32'd1);
    check("pp_head",     32'(out_onehot), 32'h08);
    in_valid = 1'b0;
    step();
    check("pp_drain", 32'(out_valid), 32'd0);

    // Plain clear.
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_err_flag", 32'(err_flag), 32'd0);
    check("clr_err_cnt",  32'(err_cnt),  32'd0);

    // Invalid push coinciding with clear: set wins, count becomes one.
    in_code  = 5'd9;
    in_valid = 1'b1;
    clr_err  = 1'b1;
    step();
    clr_err  = 1'b0;
    in_valid = 1'b0;
    check("coinc_err_flag", 32'(err_flag), 32'd1);
    check("coinc_err_cnt",  32'(err_cnt),  cnt_exp(1));
    check("coinc_out_err",  32'(out_err),  32'd1);
    step();

    // Saturation: 300 more invalid codes on top of the existing one.
    in_code  = 5'd31;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    check("sat_err_cnt",  32'(err_cnt),  cnt_exp(301));
    check("sat_err_flag", 32'(err_flag), 32'd1);
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("sat_clr_cnt",  32'(err_cnt),  32'd0);
    check("sat_clr_flag", 32'(err_flag), 32'd0);

    // Asynchronous reset while full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 5'd1;
    step();
    in_code = 5'd6;
    step();
    in_valid = 1'b0;
    check("ar_full_ready", 32'(in_ready), 32'd0);
    check("ar_full_flag",  32'(err_flag), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid),  32'd0);
    check("ar_in_ready",  32'(in_ready),   32'd1);
    check("ar_onehot",    32'(out_onehot), 32'd0);
    check("ar_err_flag",  32'(err_flag),   32'd0);
    #2;
    rst_n = 1'b1;
    in_code  = 5'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ar_post_valid", 32'(out_valid),  32'd1);
    check("ar_post_head",  32'(out_onehot), 32'h04);
    check("ar_post_ready", 32'(in_ready),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
